serial_word_tx: RTL and testbench

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/serial_word_tx_pkg.sv | 16 +
 rtl/bit_period_counter.sv | 28 ++
 rtl/serial_word_tx.sv | 111 +++++++++++
 tb/tb_serial_word_tx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_word_tx_pkg.sv
// Shared constants for serial_word_tx: state encodings, data width and counter widths.
// The optional parity state is only reachable when SERIAL_WORD_TX_PARITY_EN is defined.
package serial_word_tx_pkg;

    localparam int DATA_W  = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 8;
    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/bit_period_counter.sv
// Bit-period counter for serial_word_tx: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Wraps to 0 on its own tick, so every bit/state boundary restarts the period.
module bit_period_counter
    import serial_word_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_word_tx.sv
// 4-bit serial frame transmitter: start bit, D[0]..D[3], optional even parity, stop bit.
// Define SERIAL_WORD_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DATA_W-1:0]  D,
    output logic               ready,
    output logic               busy,
    output logic               tx,
    output logic               done,
    output logic [STATE_W-1:0] state_dbg
);

    logic [STATE_W-1:0] state;
    logic [DATA_W-1:0]  shreg;
    logic [IDX_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   next_idx;
    logic               tick;

    assign next_idx  = bit_idx + IDX_W'(1);
    assign state_dbg = state;

    // Counter is held at zero while idle so START always gets a full period.
    bit_period_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_period_counter (
        .clk  (clk),
        .reset(reset),
        .clear(state == ST_IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shreg   <= D;
                        bit_idx <= '0;
                        state   <= ST_START;
                        tx      <= 1'b0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        tx    <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
                            state <= ST_PARITY;
                            tx    <= ^shreg;
`else
                            state <= ST_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= next_idx;
                            tx      <= shreg[next_idx];
                        end
                    end
                end
`ifdef SERIAL_WORD_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        state   <= ST_IDLE;
                        bit_idx <= '0;
                        tx      <= 1'b1;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (4 and 1 clocks per bit) share stimulus and are
// checked every cycle against a frame-position model; instance 0 frames are also decoded.
module tb_serial_word_tx;

    localparam int C0 = 4;
    localparam int C1 = 1;
`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam int NSEG = 7;
`else
    localparam int NSEG = 6;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] D = 4'd0;

    logic [1:0] tx_o, ready_o, busy_o, done_o;
    logic [2:0] st0, st1;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // model state per instance: pos 0 = idle, 1..NSEG*period = frame cycle index
    int         pos[2];
    logic [3:0] cap[2];
    logic       e_done[2];
    logic [3:0] exp_q[$];

    int         rx_cnt = 0;
    logic [3:0] rx_word = 4'd0;

    always #5 clk = ~clk;

    serial_word_tx #(.CLKS_PER_BIT(C0)) u4 (
        .clk(clk), .reset(reset), .load(load), .D(D),
        .ready(ready_o[0]), .busy(busy_o[0]), .tx(tx_o[0]), .done(done_o[0]),
        .state_dbg(st0)
    );

    serial_word_tx #(.CLKS_PER_BIT(C1)) u1 (
        .clk(clk), .reset(reset), .load(load), .D(D),
        .ready(ready_o[1]), .busy(busy_o[1]), .tx(tx_o[1]), .done(done_o[1]),
        .state_dbg(st1)
    );

    function automatic int period(input int k);
        return (k == 0) ? C0 : C1;
    endfunction

    function automatic logic exp_tx(input int k);
        int seg;
        if (pos[k] == 0) return 1'b1;
        seg = (pos[k] - 1) / period(k);
        if (seg == 0) return 1'b0;
        if (seg <= 4) return cap[k][seg-1];
`ifdef SERIAL_WORD_TX_PARITY_EN
        if (seg == 5) return cap[k][0] ^ cap[k][1] ^ cap[k][2] ^ cap[k][3];
`endif
        return 1'b1;
    endfunction

    // reference model advances on each rising edge using the inputs presented to the DUTs
    initial begin
        for (int k = 0; k < 2; k++) begin
            pos[k] = 0; cap[k] = 4'd0; e_done[k] = 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            e_done[k] = 1'b0;
            if (reset) begin
                pos[k] = 0;
            end else if (pos[k] == NSEG * period(k)) begin
                pos[k] = 0;
                e_done[k] = 1'b1;
            end else if (pos[k] > 0) begin
                pos[k]++;
            end else if (load) begin
                pos[k] = 1;
                cap[k] = D;
                if (k == 0) exp_q.push_back(D);
            end
        end
        if (reset) exp_q.delete();
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("tx%0d", k),    {7'd0, tx_o[k]},    {7'd0, exp_tx(k)});
            check($sformatf("ready%0d", k), {7'd0, ready_o[k]}, {7'd0, pos[k] == 0});
            check($sformatf("busy%0d", k),  {7'd0, busy_o[k]},  {7'd0, pos[k] != 0});
            check($sformatf("done%0d", k),  {7'd0, done_o[k]},  {7'd0, e_done[k]});
        end
        // decode instance 0 from the line itself, sampling mid-bit
        if (busy_o[0]) begin
            rx_cnt++;
            if (rx_cnt >= C0 + 2 && rx_cnt <= 4 * C0 + 2 && (rx_cnt - 2) % C0 == 0)
                rx_word[(rx_cnt - 2) / C0 - 1] = tx_o[0];
        end else begin
            rx_cnt = 0;
        end
        if (done_o[0]) begin
            check("frame_pending", {7'd0, exp_q.size() != 0}, 8'd1);
            if (exp_q.size() != 0) check("frame_data", {4'd0, rx_word}, {4'd0, exp_q.pop_front()});
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [3:0] d);
        reset = r;
        load  = l;
        D     = d;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [3:0] d;
        // reset for 3 cycles, then quiet idle
        repeat (3) step(1'b1, 1'b0, 4'd0);
        repeat (4) step(1'b0, 1'b0, 4'd0);

        // single frame of 4'b1011
        step(1'b0, 1'b1, 4'b1011);
        repeat (30) step(1'b0, 1'b0, 4'd0);

        // load toggling every 2 cycles, D changing every 10 cycles
        d = 4'($urandom);
        for (int i = 0; i < 80; i++) begin
            if (i % 10 == 0) d = 4'($urandom);
            step(1'b0, ((i / 2) % 2) == 1, d);
        end
        repeat (30) step(1'b0, 1'b0, 4'd0);

        // load held high with 4'b0101: back-to-back frames
        repeat (40) step(1'b0, 1'b1, 4'b0101);
        repeat (30) step(1'b0, 1'b0, 4'd0);

        // reset while instance 0 is sending D[2]
        step(1'b0, 1'b1, 4'($urandom));
        repeat (3 * C0 + 1) step(1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0);
        repeat (5) step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'($urandom));
        repeat (35) step(1'b0, 1'b0, 4'd0);

        // reset and load in the same cycle: reset wins
        step(1'b1, 1'b1, 4'hF);
        step(1'b0, 1'b0, 4'd0);

        // randomized traffic with rare resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) d = 4'($urandom);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, d);
        end
        repeat (40) step(1'b0, 1'b0, 4'd0);
        check("frame_leftover", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
